// File: rtl/keypad_debounce.sv
// keypad_debounce
//   Debounces the raw 16-key matrix vector from the column scanner and serves
//   the CHIP-8 FX0A "wait for key" request.
//
//   Ports:
//     clk_in     system clock
//     rst_n      asynchronous active-low reset
//     raw_keys   raw key state from scanner, bit i = key i, 1 = pressed
//     scan_tick  one-cycle strobe, raw_keys holds a complete sweep
//     keys_down  debounced key state, 1 = pressed
//     wait_req   FX0A level request from the CPU, held until wait_ack
//     wait_ack   one-cycle pulse, FX0A satisfied
//     wait_key   index of the satisfying key, held after wait_ack
//
//   Parameter:
//     DEBOUNCE_SCANS  consecutive disagreeing sweeps needed to flip a key (1..15)
//
//   Build option:
//     KEYPAD_RELEASE_WAIT_EN  when defined, FX0A completes on the release of the
//                             pressed key (COSMAC VIP behaviour); otherwise it
//                             completes on the press itself.

module keypad_debounce #(
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic [15:0] raw_keys,
  input  logic        scan_tick,
  output logic [15:0] keys_down,
  input  logic        wait_req,
  output logic        wait_ack,
  output logic [3:0]  wait_key
);

  localparam logic [4:0] SCAN_LIMIT = 5'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
`ifdef KEYPAD_RELEASE_WAIT_EN
    HOLD,
`endif
    ACK
  } state_t;

  state_t      state;
  logic [3:0]  cnt      [16];
  logic [3:0]  cnt_next [16];
  logic [15:0] keys_next;
  logic [15:0] press_ev;
  logic [3:0]  press_idx;
  logic        press_any;
`ifdef KEYPAD_RELEASE_WAIT_EN
  logic [15:0] release_ev;
`endif

  // Per-key debounce counters; state only moves on a scan tick.
  always_comb begin
    keys_next = keys_down;
    for (int unsigned i = 0; i < 16; i++) begin
      cnt_next[i] = cnt[i];
      if (scan_tick) begin
        if (raw_keys[i] == keys_down[i]) begin
          cnt_next[i] = '0;
        end else if (({1'b0, cnt[i]} + 5'd1) == SCAN_LIMIT) begin
          keys_next[i] = ~keys_down[i];
          cnt_next[i]  = '0;
        end else begin
          cnt_next[i] = cnt[i] + 4'd1;
        end
      end
    end
  end

  // Events are taken from the next debounced vector so the wait FSM moves on
  // the same edge that updates keys_down.
  assign press_ev = keys_next & ~keys_down;
`ifdef KEYPAD_RELEASE_WAIT_EN
  assign release_ev = keys_down & ~keys_next;
`endif

  // Lowest-index press wins.
  always_comb begin
    press_idx = '0;
    press_any = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (press_ev[i] && !press_any) begin
        press_idx = 4'(i);
        press_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      keys_down <= '0;
      for (int unsigned i = 0; i < 16; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      keys_down <= keys_next;
      for (int unsigned i = 0; i < 16; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_ack <= 1'b0;
      wait_key <= '0;
    end else begin
      wait_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (wait_req) begin
            state <= ARM;
          end
        end
        ARM: begin
          if (!wait_req) begin
            state <= IDLE;
          end else if (press_any) begin
            wait_key <= press_idx;
`ifdef KEYPAD_RELEASE_WAIT_EN
            state    <= HOLD;
`else
            state    <= ACK;
            wait_ack <= 1'b1;
`endif
          end
        end
`ifdef KEYPAD_RELEASE_WAIT_EN
        HOLD: begin
          if (!wait_req) begin
            state <= IDLE;
          end else if (release_ev[wait_key]) begin
            state    <= ACK;
            wait_ack <= 1'b1;
          end
        end
`endif
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_debounce.sv
// tb_keypad_debounce
//   Directed bench for keypad_debounce with DEBOUNCE_SCANS = 4. Expected
//   FX0A keys are queued when a wait is set up and compared whenever the
//   DUT pulses wait_ack. Works in both builds of KEYPAD_RELEASE_WAIT_EN.

module tb_keypad_debounce;

  logic        clk_in;
  logic        rst_n;
  logic [15:0] raw_keys;
  logic        scan_tick;
  logic [15:0] keys_down;
  logic        wait_req;
  logic        wait_ack;
  logic [3:0]  wait_key;

  int checks = 0;
  int errors = 0;
  int acks   = 0;
  int pushed = 0;
  logic [3:0] exp_q[$];

  keypad_debounce #(.DEBOUNCE_SCANS(4)) dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .raw_keys (raw_keys),
    .scan_tick(scan_tick),
    .keys_down(keys_down),
    .wait_req (wait_req),
    .wait_ack (wait_ack),
    .wait_key (wait_key)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic tick(input logic [15:0] raw, input int n);
    repeat (n) begin
      raw_keys  = raw;
      scan_tick = 1'b1;
      @(negedge clk_in);
      scan_tick = 1'b0;
    end
  endtask

  task automatic expect_key(input logic [3:0] key);
    exp_q.push_back(key);
    pushed++;
  endtask

  // Called at the negedge where the ack should be visible.
  task automatic finish_ack(input string tag, input logic [3:0] key);
    check({tag, "_ack"}, 16'(wait_ack), 16'h1);
    check({tag, "_key"}, 16'(wait_key), 16'(key));
    wait_req = 1'b0;
    @(negedge clk_in);
    check({tag, "_ack_one_cycle"}, 16'(wait_ack), 16'h0);
  endtask

  // Scoreboard: every ack must match the oldest queued key; bit 4 flags an
  // ack nobody asked for.
  always @(negedge clk_in) begin
    if (rst_n === 1'b1 && wait_ack === 1'b1) begin
      logic [4:0] exp_v;
      acks++;
      checks++;
      exp_v = (exp_q.size() > 0) ? {1'b0, exp_q.pop_front()} : 5'h10;
      assert ({1'b0, wait_key} === exp_v) else begin
        errors++;
        $error("FAIL scoreboard_ack: observed %h expected %h", {1'b0, wait_key}, exp_v);
      end
    end
  end

  initial begin
    rst_n     = 1'b1;
    raw_keys  = 16'hFFFF;
    scan_tick = 1'b0;
    wait_req  = 1'b0;
    #1 rst_n = 1'b0;

    // Reset with all raw keys pressed and no ticks.
    cycle(2);
    check("reset_keys", keys_down, 16'h0000);
    check("reset_ack", 16'(wait_ack), 16'h0);
    check("reset_key", 16'(wait_key), 16'h0);
    rst_n = 1'b1;
    cycle(5);
    check("idle_no_tick_keys", keys_down, 16'h0000);

    // Debounce latency and release.
    tick(16'h0020, 3);
    check("deb_3_ticks", keys_down, 16'h0000);
    tick(16'h0020, 1);
    check("deb_4_ticks", keys_down, 16'h0020);
    tick(16'h0000, 4);
    check("deb_release", keys_down, 16'h0000);

    // Glitch: 3 disagreeing ticks then agreement clears the count.
    tick(16'h0020, 3);
    tick(16'h0000, 1);
    check("glitch_filtered", keys_down, 16'h0000);
    tick(16'h0020, 1);
    check("glitch_cnt_cleared", keys_down, 16'h0000);
    tick(16'h0020, 3);
    check("deb_after_glitch", keys_down, 16'h0020);
    tick(16'h0000, 4);

    // FX0A with keys 0xA and 0x3 debounced on the same tick.
    wait_req = 1'b1;
    cycle(2);
    expect_key(4'h3);
    tick(16'h0408, 3);
    check("fx0a_no_early_ack", 16'(wait_ack), 16'h0);
    tick(16'h0408, 1);
    check("fx0a_keys", keys_down, 16'h0408);
`ifdef KEYPAD_RELEASE_WAIT_EN
    check("fx0a_hold_no_ack", 16'(wait_ack), 16'h0);
    tick(16'h0400, 3);
    check("fx0a_rel_no_early_ack", 16'(wait_ack), 16'h0);
    tick(16'h0400, 1);
`endif
    finish_ack("fx0a_lowest", 4'h3);
    tick(16'h0000, 4);

    // Key 0x5 pre-held before the request does not satisfy it.
    tick(16'h0020, 4);
    check("preheld_keys", keys_down, 16'h0020);
    wait_req = 1'b1;
    cycle(2);
    expect_key(4'h1);
    tick(16'h0020, 4);
    check("preheld_no_ack", 16'(wait_ack), 16'h0);
    tick(16'h0022, 4);
    check("preheld_new_keys", keys_down, 16'h0022);
`ifdef KEYPAD_RELEASE_WAIT_EN
    tick(16'h0020, 4);
`endif
    finish_ack("preheld_new_press", 4'h1);
    tick(16'h0000, 4);

    // Abort in ARM: no ack, wait_key unchanged, later presses ignored.
    wait_req = 1'b1;
    cycle(3);
    wait_req = 1'b0;
    cycle(2);
    tick(16'h0200, 4);
    check("abort_keys", keys_down, 16'h0200);
    check("abort_no_ack", 16'(wait_ack), 16'h0);
    check("abort_key_held", 16'(wait_key), 16'h1);
    tick(16'h0000, 4);

`ifdef KEYPAD_RELEASE_WAIT_EN
    // Release mode: key 0x2 toggles while 0x7 is held.
    wait_req = 1'b1;
    cycle(2);
    expect_key(4'h7);
    tick(16'h0080, 4);
    check("rel_hold_key", 16'(wait_key), 16'h7);
    tick(16'h0084, 4);
    check("rel_other_press", 16'(wait_ack), 16'h0);
    tick(16'h0080, 4);
    check("rel_other_release", 16'(wait_ack), 16'h0);
    tick(16'h0000, 3);
    check("rel_no_early_ack", 16'(wait_ack), 16'h0);
    tick(16'h0000, 1);
    finish_ack("rel_key7", 4'h7);
`endif

    // Asynchronous reset in the middle of a wait and a debounce.
    wait_req = 1'b1;
    cycle(2);
`ifdef KEYPAD_RELEASE_WAIT_EN
    tick(16'h0100, 4);
    check("hold_before_reset", 16'(wait_key), 16'h8);
`else
    tick(16'h0100, 3);
`endif
    #2 rst_n = 1'b0;
    #1;
    check("midreset_keys", keys_down, 16'h0000);
    check("midreset_ack", 16'(wait_ack), 16'h0);
    check("midreset_key", 16'(wait_key), 16'h0);
    wait_req = 1'b0;
    @(negedge clk_in);
    rst_n = 1'b1;
    tick(16'h0100, 1);
    check("post_reset_cnt_cleared", keys_down, 16'h0000);
    tick(16'h0100, 3);
    check("post_reset_deb", keys_down, 16'h0100);
    cycle(3);
    check("post_reset_no_ack", 16'(wait_ack), 16'h0);

    check("queue_drained", 16'(exp_q.size()), 16'h0);
    check("ack_count", 16'(acks), 16'(pushed));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
